// File: rtl/bidir_counter_sequencer_pkg.sv
// Shared encodings and defaults for the bidirectional counter sequencer.
// State codes are fixed so the state port reads IDLE=0, RUN=1, PAUSE=2.
package bidir_counter_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_e;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    localparam int DEF_WIDTH   = 4;
    localparam int DEF_MIN_VAL = 0;
    localparam int DEF_MAX_VAL = 9;

endpackage

// File: rtl/bidir_counter_sequencer_tick_prescaler.sv
// Count-enable pacer: one-cycle tick every PRESCALE cycles while run is high.
// The count is held at zero whenever run is low.
module tick_prescaler #(
    parameter int PRESCALE = 25000000
) (
    input  logic clki,
    input  logic reset,
    input  logic run,
    output logic tick
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] TC = PW'(PRESCALE - 1);

    logic [PW-1:0] cnt_q;
    logic [PW-1:0] cnt_d;

    always_comb begin
        tick  = 1'b0;
        cnt_d = '0;
        if (run) begin
            if (cnt_q == TC) begin
                tick = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clki) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/bidir_counter_sequencer.sv
// Run/pause/step/clear controller for a bouncing MIN_VAL..MAX_VAL counter.
// Optional macro DWELL_TICKS_EN: hold DWELL_TICKS ticks at a limit before reversing.
module bidir_counter_sequencer
    import bidir_counter_sequencer_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int MIN_VAL     = DEF_MIN_VAL,
    parameter int MAX_VAL     = DEF_MAX_VAL,
    parameter int PRESCALE    = 25000000,
    parameter int DWELL_TICKS = 2
) (
    input  logic             clki,
    input  logic             reset,
    input  logic             run_req,
    input  logic             step_req,
    input  logic             clear_req,
    input  logic [WIDTH-1:0] q_in,
    output logic             cnt_en,
    output logic             cnt_up,
    output logic             cnt_clr,
    output logic [1:0]       state
);

    localparam logic [WIDTH-1:0] MIN_Q = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_VAL);

    if (PRESCALE < 2 || DWELL_TICKS < 0) begin : g_bad_cfg
        $error("bidir_counter_sequencer: invalid PRESCALE or DWELL_TICKS");
    end

    state_e state_q, state_d;
    logic   dir_q, dir_d;
    logic   en_q, en_d;
    logic   up_q, up_d;
    logic   clr_q, clr_d;
    logic   tick;
    logic   pre_run;
    logic   step_go;
    logic   at_lim;

    // Leaving RUN or clearing zeroes the prescaler in the same cycle.
    assign pre_run = (state_q == ST_RUN) && run_req && !clear_req;

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clki  (clki),
        .reset (reset),
        .run   (pre_run),
        .tick  (tick)
    );

    assign at_lim = (dir_q == DIR_UP) ? (q_in >= MAX_Q) : (q_in <= MIN_Q);

`ifdef DWELL_TICKS_EN
    localparam int DW = $clog2(DWELL_TICKS + 2);
    localparam logic [DW-1:0] DT = DW'(DWELL_TICKS);

    logic [DW-1:0] dw_q, dw_d;
    logic          hold;

    // Only paced ticks dwell; a manual step reverses at once.
    assign hold = at_lim && (state_q == ST_RUN) && (dw_q < DT);

    always_comb begin
        dw_d = dw_q;
        if (clear_req || (state_q != ST_RUN) || !run_req) begin
            dw_d = '0;
        end else if (step_go) begin
            dw_d = hold ? dw_q + 1'b1 : '0;
        end
    end

    always_ff @(posedge clki) begin
        if (reset) begin
            dw_q <= '0;
        end else begin
            dw_q <= dw_d;
        end
    end
`else
    logic hold;
    assign hold = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        en_d    = 1'b0;
        up_d    = up_q;
        clr_d   = 1'b0;
        step_go = 1'b0;
        if (clear_req) begin
            clr_d   = 1'b1;
            state_d = ST_IDLE;
            dir_d   = DIR_UP;
            up_d    = DIR_UP;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (run_req) state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (!run_req) state_d = ST_PAUSE;
                    else          step_go = tick;
                end
                ST_PAUSE: begin
                    if (run_req) state_d = ST_RUN;
                    else         step_go = step_req;
                end
                default: state_d = ST_IDLE;
            endcase
        end
        if (step_go && !hold) begin
            en_d  = 1'b1;
            dir_d = at_lim ? ~dir_q : dir_q;
            up_d  = at_lim ? ~dir_q : dir_q;
        end
    end

    always_ff @(posedge clki) begin
        if (reset) begin
            state_q <= ST_IDLE;
            dir_q   <= DIR_UP;
            en_q    <= 1'b0;
            up_q    <= DIR_UP;
            clr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            en_q    <= en_d;
            up_q    <= up_d;
            clr_q   <= clr_d;
        end
    end

    assign cnt_en  = en_q;
    assign cnt_up  = up_q;
    assign cnt_clr = clr_q;
    assign state   = state_q;

endmodule
